seg7_scan_driver: RTL and testbench

//   Downstream consumer of the 4-bit one-hot ring-counter phase.
//   - Uses the active phase to select one of NDIG hex digits and drive the

---
 rtl/seg7_pkg.sv | 32 +++
 rtl/hex7seg.sv | 31 +++
 rtl/seg7_scan_driver.sv | 149 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types for the 7-segment scan driver: segment encodings ({g,f,e,d,c,b,a},
// active-high) and the scan FSM state enum.
package seg7_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_0   = 7'h3F;
   localparam seg_t SEG_1   = 7'h06;
   localparam seg_t SEG_2   = 7'h5B;
   localparam seg_t SEG_3   = 7'h4F;
   localparam seg_t SEG_4   = 7'h66;
   localparam seg_t SEG_5   = 7'h6D;
   localparam seg_t SEG_6   = 7'h7D;
   localparam seg_t SEG_7   = 7'h07;
   localparam seg_t SEG_8   = 7'h7F;
   localparam seg_t SEG_9   = 7'h6F;
   localparam seg_t SEG_A   = 7'h77;
   localparam seg_t SEG_B   = 7'h7C;
   localparam seg_t SEG_C   = 7'h39;
   localparam seg_t SEG_D   = 7'h5E;
   localparam seg_t SEG_E   = 7'h79;
   localparam seg_t SEG_F   = 7'h71;
   localparam seg_t SEG_OFF = 7'h00;

   typedef enum logic [1:0] {
      S_WAIT,
      S_BLANK,
      S_DRIVE,
      S_FAULT
   } state_e;

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to 7-segment decode, active-high {g,f,e,d,c,b,a}.
module hex7seg
   import seg7_pkg::*;
(
   input  logic [3:0] nib_i,
   output seg_t       seg_o
);

   always_comb begin
      seg_o = SEG_OFF;
      case (nib_i)
         4'h0: seg_o = SEG_0;
         4'h1: seg_o = SEG_1;
         4'h2: seg_o = SEG_2;
         4'h3: seg_o = SEG_3;
         4'h4: seg_o = SEG_4;
         4'h5: seg_o = SEG_5;
         4'h6: seg_o = SEG_6;
         4'h7: seg_o = SEG_7;
         4'h8: seg_o = SEG_8;
         4'h9: seg_o = SEG_9;
         4'hA: seg_o = SEG_A;
         4'hB: seg_o = SEG_B;
         4'hC: seg_o = SEG_C;
         4'hD: seg_o = SEG_D;
         4'hE: seg_o = SEG_E;
         4'hF: seg_o = SEG_F;
      endcase
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-seg driver slaved to a one-hot ring-counter phase, with blanking after
// each phase change, frame-synchronous digit updates and fault detection.
// Optional leading-zero blanking: define LZB_EN.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int unsigned NDIG       = 4,
   parameter int unsigned BLANK_CYC  = 2,
   parameter int unsigned SEG_ACT_LO = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NDIG-1:0]   phase_i,
   input  logic [4*NDIG-1:0] digits_i,
   input  logic              load_i,
   output logic [6:0]        seg_o,
   output logic [NDIG-1:0]   an_o,
   output logic              frame_o,
   output logic              err_o
);

   localparam logic [3:0]      BlankInit = 4'(BLANK_CYC);
   localparam logic [NDIG-1:0] PhFirst   = {{(NDIG-1){1'b0}}, 1'b1};
   localparam logic [NDIG-1:0] PhLast    = {1'b1, {(NDIG-1){1'b0}}};

   logic [NDIG-1:0]   ph_q, ph_prev_q;
   logic [4*NDIG-1:0] staging_q, shadow_q;
   logic              pending_q;
   state_e            state_q;
   logic [3:0]        cnt_q;
   logic              err_q;
   logic [NDIG-1:0]   an_q;
   seg_t              seg_q;

   logic       chg, onehot, bad_pat, bad_chg, boundary;
   logic [3:0] nib;
   seg_t       dec_seg, drive_seg;

   assign chg      = (ph_q != ph_prev_q);
   assign onehot   = $onehot(ph_q);
   assign bad_pat  = (ph_q != '0) && !onehot;
   // Leaving all-zero is always fine; otherwise only a single rotate-left is allowed.
   assign bad_chg  = chg && (ph_prev_q != '0) &&
                     (ph_q != {ph_prev_q[NDIG-2:0], ph_prev_q[NDIG-1]});
   assign boundary = (ph_prev_q == PhLast) && (ph_q == PhFirst);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ph_q      <= '0;
         ph_prev_q <= '0;
         staging_q <= '0;
         shadow_q  <= '0;
         pending_q <= 1'b0;
      end else begin
         ph_q      <= phase_i;
         ph_prev_q <= ph_q;
         if (boundary && pending_q) begin
            shadow_q  <= staging_q;
            pending_q <= 1'b0;
         end
         // A load on the boundary cycle lands in staging and waits for the next frame.
         if (load_i) begin
            staging_q <= digits_i;
            pending_q <= 1'b1;
         end
      end
   end

   always_comb begin
      nib = '0;
      for (int i = 0; i < NDIG; i++) begin
         if (ph_q[i]) nib = shadow_q[4*i +: 4];
      end
   end

   hex7seg u_hex7seg (
      .nib_i (nib),
      .seg_o (dec_seg)
   );

`ifdef LZB_EN
   logic lz;

   always_comb begin
      lz = 1'b0;
      for (int i = 1; i < NDIG; i++) begin
         if (ph_q[i] && ((shadow_q >> (4*i)) == '0)) lz = 1'b1;
      end
   end

   assign drive_seg = lz ? SEG_OFF : dec_seg;
`else
   assign drive_seg = dec_seg;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_WAIT;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         an_q    <= '1;
         seg_q   <= SEG_OFF;
      end else begin
         an_q  <= '1;
         seg_q <= SEG_OFF;
         if (state_q != S_FAULT && (bad_pat || bad_chg)) begin
            state_q <= S_FAULT;
            err_q   <= 1'b1;
         end else begin
            unique case (state_q)
               // From FAULT any one-hot phase restarts, ignoring transition legality.
               S_WAIT, S_FAULT: begin
                  if (onehot) begin
                     state_q <= S_BLANK;
                     cnt_q   <= BlankInit;
                  end
               end
               S_BLANK: begin
                  if (chg) begin
                     cnt_q <= BlankInit;
                  end else if (cnt_q == 4'd1) begin
                     state_q <= S_DRIVE;
                     an_q    <= ~ph_q;
                     seg_q   <= drive_seg;
                  end else begin
                     cnt_q <= cnt_q - 4'd1;
                  end
               end
               S_DRIVE: begin
                  if (chg) begin
                     state_q <= S_BLANK;
                     cnt_q   <= BlankInit;
                  end else begin
                     an_q  <= ~ph_q;
                     seg_q <= drive_seg;
                  end
               end
               default: state_q <= S_WAIT;
            endcase
         end
      end
   end

   assign an_o    = an_q;
   assign seg_o   = seg_q ^ {7{SEG_ACT_LO != 0}};
   assign frame_o = boundary && pending_q;
   assign err_o   = err_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver (BLANK_CYC=2, active-low segments).
module tb_seg7_scan_driver;

   logic        clk;
   logic        rst;
   logic [3:0]  phase_i;
   logic [15:0] digits_i;
   logic        load_i;
   logic [6:0]  seg_o;
   logic [3:0]  an_o;
   logic        frame_o;
   logic        err_o;

   int errors = 0;
   int checks = 0;

   // Active-low segment patterns.
   localparam logic [6:0] L_OFF = 7'h7F;
   localparam logic [6:0] L_0   = 7'h40;
   localparam logic [6:0] L_1   = 7'h79;
   localparam logic [6:0] L_2   = 7'h24;
   localparam logic [6:0] L_3   = 7'h30;
   localparam logic [6:0] L_4   = 7'h19;
   localparam logic [6:0] L_7   = 7'h78;
   localparam logic [6:0] L_A   = 7'h08;
   localparam logic [6:0] L_B   = 7'h03;
   localparam logic [6:0] L_C   = 7'h46;
   localparam logic [6:0] L_D   = 7'h21;
`ifdef LZB_EN
   localparam logic [6:0] L_ZHI = L_OFF;
`else
   localparam logic [6:0] L_ZHI = L_0;
`endif

   seg7_scan_driver #(
      .NDIG       (4),
      .BLANK_CYC  (2),
      .SEG_ACT_LO (1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .phase_i  (phase_i),
      .digits_i (digits_i),
      .load_i   (load_i),
      .seg_o    (seg_o),
      .an_o     (an_o),
      .frame_o  (frame_o),
      .err_o    (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One 8-cycle phase step: frame pulse, blanking gap, then the driven digit.
   task automatic rot(input string t, input logic [3:0] p, input logic exp_frame,
                      input logic [3:0] exp_an, input logic [6:0] exp_seg,
                      input logic do_load, input logic [15:0] ld);
      phase_i = p;
      tick(1);
      chk({t, "/frame"}, 32'(frame_o), 32'(exp_frame));
      if (do_load) begin
         load_i   = 1'b1;
         digits_i = ld;
      end
      tick(1);
      load_i = 1'b0;
      chk({t, "/frame_end"}, 32'(frame_o), 32'd0);
      tick(1);
      chk({t, "/blank_an"}, 32'(an_o), 32'hF);
      tick(1);
      chk({t, "/an"}, 32'(an_o), 32'(exp_an));
      chk({t, "/seg"}, 32'(seg_o), 32'(exp_seg));
      tick(4);
   endtask

   initial begin
      rst      = 1'b1;
      phase_i  = 4'b0000;
      digits_i = 16'h0000;
      load_i   = 1'b0;
      tick(2);
      chk("rst_an", 32'(an_o), 32'hF);
      chk("rst_seg", 32'(seg_o), 32'(L_OFF));
      chk("rst_err", 32'(err_o), 32'd0);
      chk("rst_frame", 32'(frame_o), 32'd0);
      rst = 1'b0;
      tick(4);
      chk("wait_an", 32'(an_o), 32'hF);
      chk("wait_seg", 32'(seg_o), 32'(L_OFF));
      chk("wait_err", 32'(err_o), 32'd0);

      // Load 1234; shadow stays zero until the first 1000->0001 boundary.
      digits_i = 16'h1234;
      load_i   = 1'b1;
      tick(1);
      load_i = 1'b0;
      rot("p0", 4'b0001, 1'b0, 4'b1110, L_0,   1'b0, 16'h0);
      rot("p1", 4'b0010, 1'b0, 4'b1101, L_ZHI, 1'b0, 16'h0);
      rot("p2", 4'b0100, 1'b0, 4'b1011, L_ZHI, 1'b0, 16'h0);
      rot("p3", 4'b1000, 1'b0, 4'b0111, L_ZHI, 1'b0, 16'h0);
      rot("f1d0", 4'b0001, 1'b1, 4'b1110, L_4, 1'b0, 16'h0);
      rot("f1d1", 4'b0010, 1'b0, 4'b1101, L_3, 1'b0, 16'h0);
      rot("f1d2", 4'b0100, 1'b0, 4'b1011, L_2, 1'b0, 16'h0);
      rot("f1d3", 4'b1000, 1'b0, 4'b0111, L_1, 1'b1, 16'h0070);

      // Shadow 0070: leading zeros on digits 3 and 2.
      rot("lz0", 4'b0001, 1'b1, 4'b1110, L_0,   1'b0, 16'h0);
      rot("lz1", 4'b0010, 1'b0, 4'b1101, L_7,   1'b0, 16'h0);
      rot("lz2", 4'b0100, 1'b0, 4'b1011, L_ZHI, 1'b0, 16'h0);
      rot("lz3", 4'b1000, 1'b0, 4'b0111, L_ZHI, 1'b1, 16'h1234);

      // Load ABCD on the boundary cycle: 1234 shows now, ABCD one frame later.
      rot("b0", 4'b0001, 1'b1, 4'b1110, L_4, 1'b1, 16'hABCD);
      rot("b1", 4'b0010, 1'b0, 4'b1101, L_3, 1'b0, 16'h0);
      rot("b2", 4'b0100, 1'b0, 4'b1011, L_2, 1'b0, 16'h0);
      rot("b3", 4'b1000, 1'b0, 4'b0111, L_1, 1'b0, 16'h0);
      rot("c0", 4'b0001, 1'b1, 4'b1110, L_D, 1'b0, 16'h0);
      rot("c1", 4'b0010, 1'b0, 4'b1101, L_C, 1'b0, 16'h0);
      rot("c2", 4'b0100, 1'b0, 4'b1011, L_B, 1'b0, 16'h0);
      rot("c3", 4'b1000, 1'b0, 4'b0111, L_A, 1'b0, 16'h0);
      rot("n0", 4'b0001, 1'b0, 4'b1110, L_D, 1'b0, 16'h0);

      // Illegal jump 0001->0100.
      phase_i = 4'b0100;
      tick(2);
      chk("jump_err", 32'(err_o), 32'd1);
      chk("jump_an", 32'(an_o), 32'hF);
      chk("jump_seg", 32'(seg_o), 32'(L_OFF));
      tick(6);
      rot("jump_resume", 4'b1000, 1'b0, 4'b0111, L_A, 1'b0, 16'h0);
      chk("jump_err_sticky", 32'(err_o), 32'd1);

      // Asynchronous reset while driving.
      rst = 1'b1;
      #1;
      chk("mid_rst_an", 32'(an_o), 32'hF);
      chk("mid_rst_seg", 32'(seg_o), 32'(L_OFF));
      chk("mid_rst_err", 32'(err_o), 32'd0);
      tick(2);
      rst = 1'b0;
      tick(3);
      chk("rst_resume_blank", 32'(an_o), 32'hF);
      tick(1);
      chk("rst_resume_an", 32'(an_o), 32'b0111);
      chk("rst_resume_seg", 32'(seg_o), 32'(L_ZHI));
      chk("rst_resume_err", 32'(err_o), 32'd0);
      tick(4);

      // Illegal pattern 0011 for one cycle, then a one-hot phase.
      phase_i = 4'b0011;
      tick(1);
      phase_i = 4'b0001;
      tick(1);
      chk("pat_err", 32'(err_o), 32'd1);
      chk("pat_an", 32'(an_o), 32'hF);
      chk("pat_seg", 32'(seg_o), 32'(L_OFF));
      tick(3);
      chk("pat_resume_an", 32'(an_o), 32'b1110);
      chk("pat_resume_seg", 32'(seg_o), 32'(L_0));
      tick(3);
      rot("pat_next", 4'b0010, 1'b0, 4'b1101, L_ZHI, 1'b0, 16'h0);
      chk("pat_err_sticky", 32'(err_o), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
